int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Prioritised, nestable interrupt controller for the core's program sequencer.
- Edge-detects NUM_SRC external interrupt lines, latches them into a pending register and applies a writable enable mask.
- Arbitrates against the in-service level and presents one vector request at a time to the sequencer.
- Tracks nesting until the matching return-from-interrupt, and holds new requests off while the pipeline is stalled.

Parameters:
- NUM_SRC, 4, number of interrupt sources; bit 0 is the highest priority.
- PMA_SIZE, 16, program-memory address width, which is also the vector width.
- VEC_BASE, 16'h0040, vector address of source 0.
- VEC_STRIDE, 4, address spacing between consecutive source vectors.

Ports:
- clk, input, 1, core clock; all state is updated on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- int_src, input, NUM_SRC, interrupt lines, already synchronous to clk; a 0->1 transition is an event.
- imask_wen, input, 1, mask write strobe.
- imask_wdata, input, NUM_SRC, new mask value; 1 = enabled.
- stall, input, 1, pipeline stalled; no new request may be raised.
- ps_int_ack, input, 1, sequencer has taken the vector; meaningful only while int_req=1.
- ps_rti, input, 1, sequencer executed an RTI; one-cycle pulse.
- int_req, output, 1, interrupt request to the sequencer.
- int_vec, output, PMA_SIZE, vector address; stable while int_req=1.
- irptl, output, NUM_SRC, pending (latched) interrupts.
- imask, output, NUM_SRC, current mask.
- int_isr, output, NUM_SRC, in-service bits, i.e. the nesting record.
- rti_err, output, 1, sticky flag: an RTI arrived with no interrupt in service.

Behaviour:
- Reset, asynchronous:
  - int_req=0, int_vec=VEC_BASE.
  - irptl=0, imask=0 (all masked), int_isr=0, rti_err=0.
  - int_src previous-sample register=0; FSM=S_IDLE.
- Edge detect:
  - int_src is sampled every clock.
  - A bit that is 1 now and was 0 at the previous edge sets its irptl bit at this edge.
  - Level-held lines do not re-trigger.
- Mask:
  - When imask_wen=1, imask<=imask_wdata at the edge.
  - Masking never clears irptl; a masked pending bit fires once it is unmasked.
- Eligible set = irptl & imask. The winner is the lowest-index eligible bit.
- The winner qualifies only if its index is strictly lower than the lowest set bit of int_isr, or if int_isr=0.
- FSM, two states:
  - S_IDLE: if a winner qualifies and stall=0, then at the edge int_req<=1, latch winner index k, int_vec<=VEC_BASE+k*VEC_STRIDE (truncated to PMA_SIZE bits), and go to S_REQ.
  - S_REQ: int_req, int_vec and k are held regardless of stall, mask writes or new higher-priority events. On ps_int_ack=1: int_req<=0, irptl[k]<=0, int_isr[k]<=1, go to S_IDLE.
- Latency:
  - int_src rises and is sampled at edge N; irptl is set after edge N.
  - int_req=1 after edge N+1 when the winner qualifies and stall=0.
  - After an ack, the earliest next request is one edge later.
- RTI:
  - ps_rti clears the lowest set bit of int_isr, which is the most recent and highest-priority nesting level.
  - If int_isr=0, rti_err<=1, which stays set until reset.
  - RTI and ack in the same cycle: the RTI clears first, then the isr bit for k is set.
- Simultaneous events:
  - A new edge on source k in the same cycle as the ack of k leaves irptl[k]=1, so the set wins and the new event stays pending.
  - ps_int_ack while int_req=0 is ignored.
- A reset asserted mid-request drops int_req immediately, asynchronously, and discards all pending and in-service state.

Decomposition:
- Shared core package holds:
  - FSM state encoding (S_IDLE, S_REQ).
  - Default VEC_BASE and VEC_STRIDE.
- Sub-module int_prio_enc: parameterised lowest-index priority encoder with index and valid outputs.
  - Instantiated twice: once for the eligible set, once for int_isr.

Test Plan:
- Mask and priority: reset; write imask=4'b1111; pulse int_src[2] at edge N -> irptl=4'b0100 after N; int_req=1 and int_vec=16'h0048 after N+1; ack -> int_req=0, irptl=0, int_isr=4'b0100.
- Simultaneous events: with imask=4'b1111, raise int_src[3] and int_src[1] on the same edge -> first request int_vec=16'h0044. After its ack, source 3 does not fire (isr[1] is set). ps_rti -> int_isr=0, then request int_vec=16'h004C.
- Nesting: in service of source 2, raise source 0 -> int_vec=16'h0040 and int_isr=4'b0101 after ack. Raise source 3 -> no request until two RTIs leave int_isr=0.
- Masked pending: imask=4'b0000; pulse int_src[1] -> irptl=4'b0010, int_req stays 0. Write imask=4'b0010 -> int_req=1 one edge later with int_vec=16'h0044.
- Stall: hold stall=1 while source 0 is pending -> int_req stays 0. Release stall -> int_req=1 next edge. Assert stall while int_req=1 -> int_req and int_vec unchanged.
- Error and reset: ps_rti with int_isr=0 -> rti_err=1, sticky across further cycles. Assert reset while int_req=1 -> int_req=0, int_vec=16'h0040, irptl=0, int_isr=0, imask=0, rti_err=0 without waiting for clk.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
// FSM encoding and default vector layout.
package int_ctrl_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  localparam int DEF_VEC_BASE   = 32'h0040;
  localparam int DEF_VEC_STRIDE = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder.
// idx is only meaningful while vld is set.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int W  = 4,
  parameter int IW = idx_width(W)
) (
  input  logic [W-1:0]  bits,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // scan downward so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = i[IW-1:0];
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Prioritised, nestable interrupt controller.
// Edge-latched pending bits, mask, nesting record, one request at a time.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int                 NUM_SRC    = 4,
  parameter int                 PMA_SIZE   = 16,
  parameter logic [PMA_SIZE-1:0] VEC_BASE  = PMA_SIZE'(DEF_VEC_BASE),
  parameter int                 VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  int_src,
  input  logic                imask_wen,
  input  logic [NUM_SRC-1:0]  imask_wdata,
  input  logic                stall,
  input  logic                ps_int_ack,
  input  logic                ps_rti,
  output logic                int_req,
  output logic [PMA_SIZE-1:0] int_vec,
  output logic [NUM_SRC-1:0]  irptl,
  output logic [NUM_SRC-1:0]  imask,
  output logic [NUM_SRC-1:0]  int_isr,
  output logic                rti_err
);

  localparam int IW = idx_width(NUM_SRC);

  state_t              state;
  logic [NUM_SRC-1:0]  src_q;
  logic [NUM_SRC-1:0]  edges;
  logic [NUM_SRC-1:0]  eligible;
  logic [IW-1:0]       win_idx;
  logic                win_vld;
  logic [IW-1:0]       isr_idx;
  logic                isr_vld;
  logic                qualify;
  logic [IW-1:0]       k_q;
  logic                take;
  logic [NUM_SRC-1:0]  k_oh;
  logic [NUM_SRC-1:0]  isr_low_oh;
  logic [NUM_SRC-1:0]  isr_next;
  logic [PMA_SIZE-1:0] win_vec;

  assign edges    = int_src & ~src_q;
  assign eligible = irptl & imask;

  int_prio_enc #(
    .W  (NUM_SRC),
    .IW (IW)
  ) u_win_enc (
    .bits (eligible),
    .idx  (win_idx),
    .vld  (win_vld)
  );

  int_prio_enc #(
    .W  (NUM_SRC),
    .IW (IW)
  ) u_isr_enc (
    .bits (int_isr),
    .idx  (isr_idx),
    .vld  (isr_vld)
  );

  // only a strictly higher-priority source may preempt the active level
  assign qualify = win_vld && (!isr_vld || (win_idx < isr_idx));

  assign take = (state == S_REQ) && ps_int_ack;

  assign win_vec = VEC_BASE
                 + PMA_SIZE'(VEC_STRIDE) * PMA_SIZE'(win_idx);

  // one-hot forms of the granted source and the innermost nesting level
  always_comb begin
    k_oh       = '0;
    isr_low_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      k_oh[i]       = (k_q == i[IW-1:0]);
      isr_low_oh[i] = isr_vld && (isr_idx == i[IW-1:0]);
    end
  end

  // RTI pops the innermost level before an ack pushes the new one
  always_comb begin
    isr_next = int_isr;
    if (ps_rti) begin
      isr_next = isr_next & ~isr_low_oh;
    end
    if (take) begin
      isr_next = isr_next | k_oh;
    end
  end

  // previous-sample register for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q <= '0;
    end else begin
      src_q <= int_src;
    end
  end

  // software mask register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imask <= '0;
    end else if (imask_wen) begin
      imask <= imask_wdata;
    end
  end

  // pending latch: a fresh edge beats the clear of the acked source
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irptl <= '0;
    end else begin
      irptl <= (irptl & ~(take ? k_oh : '0)) | edges;
    end
  end

  // nesting record and sticky unmatched-RTI flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      int_isr <= '0;
      rti_err <= 1'b0;
    end else begin
      int_isr <= isr_next;
      if (ps_rti && !isr_vld) begin
        rti_err <= 1'b1;
      end
    end
  end

  // request FSM: raise on a qualified winner, hold until acked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      int_req <= 1'b0;
      int_vec <= VEC_BASE;
      k_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (qualify && !stall) begin
            int_req <= 1'b1;
            int_vec <= win_vec;
            k_q     <= win_idx;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (ps_int_ack) begin
            int_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          int_req <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed vector bench for int_ctrl.
// One record per clock edge, checked 1 time unit after the edge.
module tb_int_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  int_src;
  logic        imask_wen;
  logic [3:0]  imask_wdata;
  logic        stall;
  logic        ps_int_ack;
  logic        ps_rti;
  logic        int_req;
  logic [15:0] int_vec;
  logic [3:0]  irptl;
  logic [3:0]  imask;
  logic [3:0]  int_isr;
  logic        rti_err;

  int checks;
  int failures;

  typedef struct {
    logic [3:0]  src;
    logic        wen;
    logic [3:0]  wd;
    logic        stl;
    logic        ack;
    logic        rti;
    logic        req;
    logic [15:0] vec;
    logic [3:0]  pend;
    logic [3:0]  msk;
    logic [3:0]  isr;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  int_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .int_src     (int_src),
    .imask_wen   (imask_wen),
    .imask_wdata (imask_wdata),
    .stall       (stall),
    .ps_int_ack  (ps_int_ack),
    .ps_rti      (ps_rti),
    .int_req     (int_req),
    .int_vec     (int_vec),
    .irptl       (irptl),
    .imask       (imask),
    .int_isr     (int_isr),
    .rti_err     (rti_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req,
                         input logic [15:0] vec, input logic [3:0] pend,
                         input logic [3:0] msk, input logic [3:0] isr,
                         input logic err);
    chk({tag, " int_req"}, 32'(int_req), 32'(req));
    chk({tag, " int_vec"}, 32'(int_vec), 32'(vec));
    chk({tag, " irptl"},   32'(irptl),   32'(pend));
    chk({tag, " imask"},   32'(imask),   32'(msk));
    chk({tag, " int_isr"}, 32'(int_isr), 32'(isr));
    chk({tag, " rti_err"}, 32'(rti_err), 32'(err));
  endtask

  function automatic vec_t mk(
    input logic [3:0] src, input logic wen, input logic [3:0] wd,
    input logic stl, input logic ack, input logic rti,
    input logic req, input logic [15:0] vec, input logic [3:0] pend,
    input logic [3:0] msk, input logic [3:0] isr, input logic err);
    vec_t v;
    v.src = src; v.wen = wen; v.wd = wd;
    v.stl = stl; v.ack = ack; v.rti = rti;
    v.req = req; v.vec = vec; v.pend = pend;
    v.msk = msk; v.isr = isr; v.err = err;
    return v;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;

    //           src  w wd  s a r | req vec  pend msk isr err
    // mask and priority, level hold does not retrigger
    tbl.push_back(mk(4'h0,1,4'hF,0,0,0, 0,16'h40,4'h0,4'hF,4'h0,0));
    tbl.push_back(mk(4'h4,0,4'h0,0,0,0, 0,16'h40,4'h4,4'hF,4'h0,0));
    tbl.push_back(mk(4'h4,0,4'h0,0,0,0, 1,16'h48,4'h4,4'hF,4'h0,0));
    tbl.push_back(mk(4'h4,0,4'h0,0,1,0, 0,16'h48,4'h0,4'hF,4'h4,0));
    // nesting: source 0 preempts 2, source 3 waits for two RTIs
    tbl.push_back(mk(4'h1,0,4'h0,0,0,0, 0,16'h48,4'h1,4'hF,4'h4,0));
    tbl.push_back(mk(4'h1,0,4'h0,0,0,0, 1,16'h40,4'h1,4'hF,4'h4,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,1,0, 0,16'h40,4'h0,4'hF,4'h5,0));
    tbl.push_back(mk(4'h8,0,4'h0,0,0,0, 0,16'h40,4'h8,4'hF,4'h5,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 0,16'h40,4'h8,4'hF,4'h5,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,1, 0,16'h40,4'h8,4'hF,4'h4,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 0,16'h40,4'h8,4'hF,4'h4,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,1, 0,16'h40,4'h8,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 1,16'h4C,4'h8,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,1,0, 0,16'h4C,4'h0,4'hF,4'h8,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,1, 0,16'h4C,4'h0,4'hF,4'h0,0));
    // simultaneous edges on sources 3 and 1
    tbl.push_back(mk(4'hA,0,4'h0,0,0,0, 0,16'h4C,4'hA,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 1,16'h44,4'hA,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,1,0, 0,16'h44,4'h8,4'hF,4'h2,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 0,16'h44,4'h8,4'hF,4'h2,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,1, 0,16'h44,4'h8,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 1,16'h4C,4'h8,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,1,0, 0,16'h4C,4'h0,4'hF,4'h8,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,1, 0,16'h4C,4'h0,4'hF,4'h0,0));
    // masked pending fires once unmasked
    tbl.push_back(mk(4'h0,1,4'h0,0,0,0, 0,16'h4C,4'h0,4'h0,4'h0,0));
    tbl.push_back(mk(4'h2,0,4'h0,0,0,0, 0,16'h4C,4'h2,4'h0,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 0,16'h4C,4'h2,4'h0,4'h0,0));
    tbl.push_back(mk(4'h0,1,4'h2,0,0,0, 0,16'h4C,4'h2,4'h2,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 1,16'h44,4'h2,4'h2,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,1,0, 0,16'h44,4'h0,4'h2,4'h2,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,1, 0,16'h44,4'h0,4'h2,4'h0,0));
    // stall blocks raising, not holding
    tbl.push_back(mk(4'h1,1,4'hF,0,0,0, 0,16'h44,4'h1,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,1,0,0, 0,16'h44,4'h1,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,1,0,0, 0,16'h44,4'h1,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 1,16'h40,4'h1,4'hF,4'h0,0));
    tbl.push_back(mk(4'h4,1,4'h0,1,0,0, 1,16'h40,4'h5,4'h0,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,1,1,0, 0,16'h40,4'h4,4'h0,4'h1,0));
    tbl.push_back(mk(4'h0,1,4'hF,0,0,1, 0,16'h40,4'h4,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 1,16'h48,4'h4,4'hF,4'h0,0));
    // new edge on k during its ack stays pending
    tbl.push_back(mk(4'h4,0,4'h0,0,1,0, 0,16'h48,4'h4,4'hF,4'h4,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,1, 0,16'h48,4'h4,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 1,16'h48,4'h4,4'hF,4'h0,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,1,0, 0,16'h48,4'h0,4'hF,4'h4,0));
    // RTI and ack together: pop level 2 then push level 0
    tbl.push_back(mk(4'h1,0,4'h0,0,0,0, 0,16'h48,4'h1,4'hF,4'h4,0));
    tbl.push_back(mk(4'h1,0,4'h0,0,0,0, 1,16'h40,4'h1,4'hF,4'h4,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,1,1, 0,16'h40,4'h0,4'hF,4'h1,0));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,1, 0,16'h40,4'h0,4'hF,4'h0,0));
    // unmatched RTI is sticky; stray ack is ignored
    tbl.push_back(mk(4'h0,0,4'h0,0,0,1, 0,16'h40,4'h0,4'hF,4'h0,1));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 0,16'h40,4'h0,4'hF,4'h0,1));
    tbl.push_back(mk(4'h1,0,4'h0,0,1,0, 0,16'h40,4'h1,4'hF,4'h0,1));
    tbl.push_back(mk(4'h0,0,4'h0,0,0,0, 1,16'h40,4'h1,4'hF,4'h0,1));

    reset       = 1'b1;
    int_src     = '0;
    imask_wen   = 1'b0;
    imask_wdata = '0;
    stall       = 1'b0;
    ps_int_ack  = 1'b0;
    ps_rti      = 1'b0;

    #3;
    chk_all("reset", 1'b0, 16'h0040, 4'h0, 4'h0, 4'h0, 1'b0);

    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      int_src     = tbl[i].src;
      imask_wen   = tbl[i].wen;
      imask_wdata = tbl[i].wd;
      stall       = tbl[i].stl;
      ps_int_ack  = tbl[i].ack;
      ps_rti      = tbl[i].rti;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), tbl[i].req, tbl[i].vec,
              tbl[i].pend, tbl[i].msk, tbl[i].isr, tbl[i].err);
      @(negedge clk);
    end

    // request is still up here; reset must clear it without a clock
    chk("pre-reset int_req", 32'(int_req), 32'd1);
    int_src    = 4'h0;
    ps_int_ack = 1'b0;
    ps_rti     = 1'b0;
    imask_wen  = 1'b0;
    stall      = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk_all("async-reset", 1'b0, 16'h0040, 4'h0, 4'h0, 4'h0, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    int_src = 4'h1;
    @(posedge clk);
    #1;
    chk_all("post-reset", 1'b0, 16'h0040, 4'h1, 4'h0, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
